// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1-D CNN datapath blocks.
package cnn1d_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    MAC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_window.sv
// Sliding sample window: x[KERNEL_SIZE-1] takes the newest sample, x[0] holds the oldest.
module sample_window #(
  parameter int DATA_WIDTH  = 12,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_shift_en,
  input  logic [DATA_WIDTH-1:0]             i_sample,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] o_window
);

  logic [KERNEL_SIZE*DATA_WIDTH-1:0] r_window;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_window <= '0;
    end else if (i_shift_en) begin
      r_window <= {i_sample, r_window[KERNEL_SIZE*DATA_WIDTH-1:DATA_WIDTH]};
    end
  end

  assign o_window = r_window;

endmodule

// File: rtl/convolve.sv
// Streaming 1-D convolution: one shared multiplier walks the window tap by tap,
// producing one result per accepted sample once the window has filled.
module convolve
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int WEIGHT_WIDTH = 12,
  parameter int KERNEL_SIZE  = 3,
  localparam int OUT_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH + clog2(KERNEL_SIZE)
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                convolve_ready_in,
  input  logic                                convolve_valid_in,
  input  logic [DATA_WIDTH-1:0]               convolve_data_in,
  input  logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] convolve_weights_in,
  input  logic                                convolve_ready_out,
  output logic                                convolve_valid_out,
  output logic [OUT_WIDTH-1:0]                convolve_data_out,
  output state_e                              o_dbg_state
);

  localparam int TAP_W  = clog2(KERNEL_SIZE);
  localparam int CNT_W  = clog2(KERNEL_SIZE + 1);
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both
  // high; valid holds its data stable until that edge, ready never depends on valid.
  state_e                 r_state;
  state_e                 w_next_state;
  logic [CNT_W-1:0]       r_fill_cnt;
  logic [TAP_W-1:0]       r_tap;
  logic [OUT_WIDTH-1:0]   r_acc;
  logic                   r_ready_in;
  logic                   r_valid_out;
  logic [OUT_WIDTH-1:0]   r_data_out;

  logic                                w_in_hs;
  logic                                w_out_hs;
  logic                                w_last_tap;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0]   w_window;
  logic [DATA_WIDTH-1:0]               w_x_sel;
  logic [WEIGHT_WIDTH-1:0]             w_w_sel;
  logic [PROD_W-1:0]                   w_product;
  logic [OUT_WIDTH-1:0]                w_sum;

  assign w_in_hs    = convolve_valid_in && r_ready_in;
  assign w_out_hs   = r_valid_out && convolve_ready_out;
  assign w_last_tap = (r_tap == TAP_W'(KERNEL_SIZE - 1));

  sample_window #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .i_shift_en (w_in_hs),
    .i_sample   (convolve_data_in),
    .o_window   (w_window)
  );

  assign w_x_sel   = w_window[r_tap*DATA_WIDTH +: DATA_WIDTH];
  assign w_w_sel   = convolve_weights_in[r_tap*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_product = {{WEIGHT_WIDTH{1'b0}}, w_x_sel} * {{DATA_WIDTH{1'b0}}, w_w_sel};
  assign w_sum     = r_acc + {{(OUT_WIDTH-PROD_W){1'b0}}, w_product};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_in_hs && (r_fill_cnt == CNT_W'(KERNEL_SIZE - 1))) w_next_state = MAC;
      IDLE:    if (w_in_hs) w_next_state = MAC;
      MAC:     if (w_last_tap) w_next_state = HOLD;
      HOLD:    if (w_out_hs) w_next_state = IDLE;
      default: w_next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_cnt  <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_ready_in  <= 1'b1;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if ((r_state == FILL) && w_in_hs) begin
        r_fill_cnt <= r_fill_cnt + CNT_W'(1);
      end
      // Input is closed from the triggering handshake until the result is taken.
      if (w_in_hs && (w_next_state == MAC)) begin
        r_ready_in <= 1'b0;
      end else if (w_out_hs) begin
        r_ready_in <= 1'b1;
      end
      if (r_state == MAC) begin
        if (w_last_tap) begin
          r_data_out  <= w_sum;
          r_valid_out <= 1'b1;
          r_acc       <= '0;
          r_tap       <= '0;
        end else begin
          r_acc <= w_sum;
          r_tap <= r_tap + TAP_W'(1);
        end
      end else if (w_out_hs) begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign convolve_ready_in  = r_ready_in;
  assign convolve_valid_out = r_valid_out;
  assign convolve_data_out  = r_data_out;
  assign o_dbg_state        = r_state;

endmodule
